lfsr_checker: RTL

- Serial receive-side checker for the 4-bit XNOR LFSR pattern generator (feedback = ~(out[3]^out[2]), shift left, reset 0).
- Consumes the generator's per-cycle feedback bit stream, self-synchronises to it, and declares lock after a run of correct predictions.
- Once locked, flywheels on its own prediction and counts bit errors.
- Used at the far end of a link or loopback to validate pattern integrity.

---
 rtl/lfsr_checker.sv | 117 +++++++++++
 1 files changed

// File: rtl/lfsr_checker.sv
// Receive-side checker for the XNOR LFSR pattern: seeds from the incoming
// bit stream, hunts for a run of correct predictions, then flywheels and counts errors.
module lfsr_checker #(
  parameter int unsigned WIDTH       = 4,
  parameter int unsigned TAP_A       = 3,
  parameter int unsigned TAP_B       = 2,
  parameter int unsigned LOCK_COUNT  = 8,
  parameter int unsigned UNLOCK_ERRS = 4,
  parameter int unsigned ERR_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic             in_bit,
  input  logic             clr_count,
  output logic             locked,
  output logic             err_pulse,
  output logic [ERR_W-1:0] err_count
);

  localparam int unsigned SW = $clog2(WIDTH + 1);
  localparam int unsigned MW = $clog2(LOCK_COUNT + 1);
  localparam int unsigned UW = $clog2(UNLOCK_ERRS + 1);

  typedef enum logic [1:0] {SEED, HUNT, LOCKED} state_t;

  state_t           state, state_nx;
  logic [WIDTH-1:0] hist, hist_nx;
  logic [SW-1:0]    seed_cnt, seed_nx;
  logic [MW-1:0]    match_cnt, match_nx;
  logic [UW-1:0]    miss_cnt, miss_nx;
  logic [ERR_W-1:0] cnt_nx;
  logic             err_nx;
  logic             pred;
  logic             mismatch;

  assign pred     = ~(hist[TAP_A] ^ hist[TAP_B]);
  assign mismatch = (in_bit != pred);

  always_comb begin
    state_nx = state;
    hist_nx  = hist;
    seed_nx  = seed_cnt;
    match_nx = match_cnt;
    miss_nx  = miss_cnt;
    err_nx   = 1'b0;
    if (in_valid) begin
      case (state)
        SEED: begin
          hist_nx = {hist[WIDTH-2:0], in_bit};
          seed_nx = seed_cnt + SW'(1);
          if (seed_nx == SW'(WIDTH)) begin
            state_nx = HUNT;
            match_nx = '0;
          end
        end
        HUNT: begin
          hist_nx = {hist[WIDTH-2:0], in_bit};
          // The all-ones window is the XNOR lockup state and never counts toward lock.
          if (!mismatch && (hist != '1)) begin
            match_nx = match_cnt + MW'(1);
            if (match_nx == MW'(LOCK_COUNT)) begin
              state_nx = LOCKED;
              miss_nx  = '0;
            end
          end else begin
            match_nx = '0;
          end
        end
        LOCKED: begin
          hist_nx = {hist[WIDTH-2:0], pred};
          if (mismatch) begin
            err_nx  = 1'b1;
            miss_nx = miss_cnt + UW'(1);
            if (miss_nx == UW'(UNLOCK_ERRS)) begin
              state_nx = SEED;
              seed_nx  = '0;
            end
          end else begin
            miss_nx = '0;
          end
        end
        default: state_nx = SEED;
      endcase
    end
  end

  // Clear takes effect before the current error is added, so clear+error yields 1.
  always_comb begin
    cnt_nx = clr_count ? '0 : err_count;
    if (err_nx && (cnt_nx != '1))
      cnt_nx = cnt_nx + ERR_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= SEED;
      hist      <= '0;
      seed_cnt  <= '0;
      match_cnt <= '0;
      miss_cnt  <= '0;
      locked    <= 1'b0;
      err_pulse <= 1'b0;
      err_count <= '0;
    end else begin
      state     <= state_nx;
      hist      <= hist_nx;
      seed_cnt  <= seed_nx;
      match_cnt <= match_nx;
      miss_cnt  <= miss_nx;
      locked    <= (state_nx == LOCKED);
      err_pulse <= err_nx;
      err_count <= cnt_nx;
    end
  end

endmodule
